// File: rtl/capture_8seg_if.sv
// capture_8seg_if: display-bus tap (sel/leds in) and decoded digit readback (out).
interface capture_8seg_if #(
  parameter int DIGITS = 4
) ();
  logic [DIGITS-1:0]   sel;
  logic [7:0]          leds;
  logic [4*DIGITS-1:0] tetrades;
  logic [DIGITS-1:0]   dots;
  logic [DIGITS-1:0]   known;
  logic                update;
  logic [2:0]          upd_idx;
  modport master (output sel, leds, input tetrades, dots, known, update, upd_idx);
  modport slave (input sel, leds, output tetrades, dots, known, update, upd_idx);
endinterface

// File: rtl/capture_8seg.sv
// capture_8seg: filters a multiplexed 8-segment bus and decodes each stable digit to hex + dot.
// Define CAPTURE_8SEG_ACTIVE_LOW_EN for common-anode (inverted) sel/leds inputs.
module capture_8seg #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input logic           clk,
  input logic           rst_n,
  capture_8seg_if.slave bus
);
  localparam int W  = DIGITS + 8;
  localparam int CW = $clog2(STABLE + 1);
  logic [W-1:0]        w_in, r_s1, r_s2, r_prev;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS-1:0]   w_sel;
  logic [6:0]          w_seg;
  logic                w_dot, w_onehot, w_same, w_fire, w_hit;
  logic [3:0]          w_val;
  logic [2:0]          w_idx;
  logic [4*DIGITS-1:0] r_tet;
  logic [DIGITS-1:0]   r_dots, r_known;
  logic                r_upd;
  logic [2:0]          r_idx;
`ifdef CAPTURE_8SEG_ACTIVE_LOW_EN
  assign w_in = ~{bus.sel, bus.leds};
`else
  assign w_in = {bus.sel, bus.leds};
`endif
  assign w_sel    = r_s2[W-1:8];
  assign w_dot    = r_s2[7];
  assign w_seg    = r_s2[6:0];
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_same   = r_s2 == r_prev;
  // cnt saturates at STABLE, so STABLE-1 is passed exactly once per stable interval
  assign w_fire   = w_same && (r_cnt == CW'(STABLE - 1)) && w_onehot;
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < DIGITS; k++)
      if (w_sel[k]) w_idx = 3'(k);
  end
  always_comb begin
    w_val = 4'h0;
    w_hit = 1'b1;
    case (w_seg)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= w_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_cnt  <= !w_same ? '0 : (r_cnt == CW'(STABLE)) ? r_cnt : r_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tet   <= '0;
      r_dots  <= '0;
      r_known <= '0;
      r_upd   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_upd <= w_fire;
      if (w_fire) r_idx <= w_idx;
      for (int k = 0; k < DIGITS; k++)
        if (w_fire && w_sel[k]) begin
          r_tet[4*k +: 4] <= w_hit ? w_val : 4'h0;
          r_dots[k]       <= w_dot;
          r_known[k]      <= w_hit;
        end
    end
  end
  assign bus.tetrades = r_tet;
  assign bus.dots     = r_dots;
  assign bus.known    = r_known;
  assign bus.update   = r_upd;
  assign bus.upd_idx  = r_idx;
endmodule

// File: tb/tb_capture_8seg.sv
// tb_capture_8seg: table-driven stimulus with a capture scoreboard for capture_8seg.
module tb_capture_8seg;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct {
    logic [3:0] sel;
    logic [7:0] leds;
    int         cyc;
    bit         cap;
  } vec_t;
  typedef struct {
    logic [2:0]  idx;
    logic [15:0] tet;
    logic [3:0]  dots;
    logic [3:0]  known;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  capture_8seg_if #(.DIGITS(DIGITS)) bus ();
  capture_8seg #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t        sb[$];
  exp_t        got;
  logic [15:0] m_tet   = '0;
  logic [3:0]  m_dots  = '0;
  logic [3:0]  m_known = '0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  bit          prev_upd = 1'b0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] decode(logic [6:0] g);
    decode = 5'h00;
    for (int k = 0; k < 16; k++)
      if (g == GLY[k]) decode = {1'b1, 4'(k)};
  endfunction
  task automatic drive(logic [3:0] s, logic [7:0] l);
`ifdef CAPTURE_8SEG_ACTIVE_LOW_EN
    bus.sel  = ~s;
    bus.leds = ~l;
`else
    bus.sel  = s;
    bus.leds = l;
`endif
  endtask
  task automatic expect_cap(logic [3:0] s, logic [7:0] l);
    logic [4:0] d;
    int i;
    d = decode(l[6:0]);
    i = 0;
    for (int k = 0; k < DIGITS; k++)
      if (s[k]) i = k;
    m_tet[4*i +: 4] = d[3:0];
    m_dots[i]       = l[7];
    m_known[i]      = d[4];
    sb.push_back('{3'(i), m_tet, m_dots, m_known});
  endtask
  task automatic apply(vec_t v);
    if (v.cap) expect_cap(v.sel, v.leds);
    drive(v.sel, v.leds);
    repeat (v.cyc) @(posedge clk);
    #1;
    check("pending", sb.size(), 0);
    check("hold_tet", bus.tetrades, m_tet);
    check("hold_dots", bus.dots, m_dots);
    check("hold_known", bus.known, m_known);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.update) begin
        check("upd_gap", prev_upd, 0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_update: idx=%0d tet=%0h expected no update at %0t", bus.upd_idx, bus.tetrades, $time);
        end else begin
          got = sb.pop_front();
          check("upd_idx", bus.upd_idx, got.idx);
          check("tetrades", bus.tetrades, got.tet);
          check("dots", bus.dots, got.dots);
          check("known", bus.known, got.known);
        end
      end
      prev_upd = bus.update;
    end
  end
  initial begin
    vec_t tbl[$];
    int   first;
    for (int k = 0; k < 16; k++)
      tbl.push_back('{4'b0100, {1'(k & 1), GLY[k]}, 10, 1'b1});
    tbl.push_back('{4'b0010, 8'h49, 10, 1'b1});
    tbl.push_back('{4'b0010, 8'h00, 10, 1'b1});
    tbl.push_back('{4'b1000, 8'h86, 10, 1'b1});
    tbl.push_back('{4'b0001, 8'h5B, 12, 1'b1});
    tbl.push_back('{4'b0001, 8'h06,  3, 1'b0});
    tbl.push_back('{4'b0001, 8'h5B, 12, 1'b1});
    tbl.push_back('{4'b0000, 8'h3F, 20, 1'b0});
    tbl.push_back('{4'b0110, 8'h3F, 20, 1'b0});
    tbl.push_back('{4'b0001, 8'h06,  8, 1'b1});
    tbl.push_back('{4'b0010, 8'h5B,  8, 1'b1});
    tbl.push_back('{4'b0100, 8'h4F,  8, 1'b1});
    tbl.push_back('{4'b1000, 8'h66,  8, 1'b1});
    drive(4'b1011, 8'hA5);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tet", bus.tetrades, 0);
    check("rst_dots", bus.dots, 0);
    check("rst_known", bus.known, 0);
    check("rst_update", bus.update, 0);
    check("rst_idx", bus.upd_idx, 0);
    drive(4'b0001, 8'h3F);
    expect_cap(4'b0001, 8'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (bus.update && first == 0) first = e;
    end
    check("latency", first, 7);
    check("first_known", bus.known, 4'b0001);
    foreach (tbl[i]) apply(tbl[i]);
    check("scan_tet", bus.tetrades, 16'h4321);
    check("scan_known", bus.known, 4'b1111);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_tet", bus.tetrades, 0);
    check("midrst_known", bus.known, 0);
    check("midrst_update", bus.update, 0);
    check("midrst_pending", sb.size(), 0);
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
